demux1x4_4b_buf: RTL and testbench

- 1-to-4 demultiplexer for 4-bit data, the inverse of the team's 4:1 4-bit mux.
- Routes one input stream to one of four output channels selected by s1,s0.
- Each output channel has a one-entry registered holding slot with a valid/ready handshake, so a single producer can feed four independent consumers.
- Sits between a shared 4-bit source and four per-lane sinks.

---
 rtl/demux1x4_4b_buf.sv | 106 ++++++++++
 tb/tb_demux1x4_4b_buf.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/demux1x4_4b_buf.sv
// 1-to-4 demultiplexer with a one-entry registered slot and valid/ready handshake per channel.
// Define DEMUX_AUTO_SEL_EN to select channels with an internal round-robin pointer (exposed on sel_q).
module demux1x4_4b_buf #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             s0,
  input  logic             s1,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] f0,
  output logic [WIDTH-1:0] f1,
  output logic [WIDTH-1:0] f2,
  output logic [WIDTH-1:0] f3,
  output logic             v0,
  output logic             v1,
  output logic             v2,
  output logic             v3,
  input  logic             r0,
  input  logic             r1,
  input  logic             r2,
  input  logic             r3,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3
`ifdef DEMUX_AUTO_SEL_EN
  ,
  output logic [1:0]       sel_q
`endif
);

  // Handshake: a transfer happens on an edge where valid & ready are both high.
  // Input side: in_valid/in_ready; channel k side: vk (slot full) / rk (consumer takes it).
  // A full slot whose consumer is ready can be reloaded in the same cycle it drains.

  logic [WIDTH-1:0] f_q   [4];
  logic [CNT_W-1:0] cnt_q [4];
  logic [3:0]       v_q;
  logic [3:0]       r_vec;
  logic [1:0]       sel;
  logic             accept;

  assign r_vec = {r3, r2, r1, r0};

`ifdef DEMUX_AUTO_SEL_EN
  logic [1:0] ptr_q;
  logic       unused_sel;

  assign unused_sel = s0 ^ s1;
  assign sel        = ptr_q;
  assign sel_q      = ptr_q;

  // Pointer advances only on an accepted transfer, so a stall holds it on the full channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 2'd0;
    end else if (accept) begin
      ptr_q <= ptr_q + 2'd1;
    end
  end
`else
  assign sel = {s1, s0};
`endif

  assign in_ready = ~rst & (~v_q[sel] | r_vec[sel]);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= 4'b0000;
      for (int k = 0; k < 4; k++) begin
        f_q[k]   <= '0;
        cnt_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (accept && (sel == 2'(k))) begin
          f_q[k]   <= d;
          v_q[k]   <= 1'b1;
          cnt_q[k] <= cnt_q[k] + CNT_W'(1);
        end else if (v_q[k] && r_vec[k]) begin
          // Data stays visible after a drain; only the valid flag drops.
          v_q[k] <= 1'b0;
        end
      end
    end
  end

  assign f0   = f_q[0];
  assign f1   = f_q[1];
  assign f2   = f_q[2];
  assign f3   = f_q[3];
  assign v0   = v_q[0];
  assign v1   = v_q[1];
  assign v2   = v_q[2];
  assign v3   = v_q[3];
  assign cnt0 = cnt_q[0];
  assign cnt1 = cnt_q[1];
  assign cnt2 = cnt_q[2];
  assign cnt3 = cnt_q[3];

endmodule

// File: tb/tb_demux1x4_4b_buf.sv
// Scoreboard bench for demux1x4_4b_buf: per-channel expected queues filled by the driver, emptied by a drain monitor.
// Build with DEMUX_AUTO_SEL_EN defined to exercise the round-robin selection.
module tb_demux1x4_4b_buf;
  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b1;
  logic [WIDTH-1:0] d = '0;
  logic             s0 = 1'b0, s1 = 1'b0, in_valid = 1'b0;
  logic             r0 = 1'b0, r1 = 1'b0, r2 = 1'b0, r3 = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] f0, f1, f2, f3;
  logic             v0, v1, v2, v3;
  logic [CNT_W-1:0] cnt0, cnt1, cnt2, cnt3;
`ifdef DEMUX_AUTO_SEL_EN
  logic [1:0]       sel_q;
`endif

  demux1x4_4b_buf #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .d(d), .s0(s0), .s1(s1),
    .in_valid(in_valid), .in_ready(in_ready),
    .f0(f0), .f1(f1), .f2(f2), .f3(f3),
    .v0(v0), .v1(v1), .v2(v2), .v3(v3),
    .r0(r0), .r1(r1), .r2(r2), .r3(r3),
    .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3)
`ifdef DEMUX_AUTO_SEL_EN
    , .sel_q(sel_q)
`endif
  );

  // Reference model: each channel is a one-deep buffer modelled as a queue.
  logic [WIDTH-1:0] exp_q [4][$];
  logic [CNT_W-1:0] cnt_m [4];
  logic [1:0]       ptr_m;
  int               checks = 0;
  int               errors = 0;
  bit               started = 1'b0;

  function automatic logic [WIDTH-1:0] f_of(int k);
    case (k)
      0: return f0;
      1: return f1;
      2: return f2;
      default: return f3;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] cnt_of(int k);
    case (k)
      0: return cnt0;
      1: return cnt1;
      2: return cnt2;
      default: return cnt3;
    endcase
  endfunction

  function automatic logic v_of(int k);
    case (k)
      0: return v0;
      1: return v1;
      2: return v2;
      default: return v3;
    endcase
  endfunction

  function automatic logic r_of(int k);
    case (k)
      0: return r0;
      1: return r1;
      2: return r2;
      default: return r3;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver task: one clock cycle of stimulus plus state / ready checks against the model.
  task automatic cycle(input logic rst_i, input logic [1:0] s_i, input logic [WIDTH-1:0] d_i,
                       input logic valid_i, input logic [3:0] r_i);
    int  k;
    bit  exp_ready;
    @(negedge clk);
    #1;
    if (started) begin
      for (int c = 0; c < 4; c++) begin
        check($sformatf("v%0d", c), int'(v_of(c)), int'(exp_q[c].size() != 0));
        check($sformatf("cnt%0d", c), int'(cnt_of(c)), int'(cnt_m[c]));
      end
`ifdef DEMUX_AUTO_SEL_EN
      check("sel_q", int'(sel_q), int'(ptr_m));
`endif
    end
    rst = rst_i; {s1, s0} = s_i; d = d_i; in_valid = valid_i;
    {r3, r2, r1, r0} = r_i;
`ifdef DEMUX_AUTO_SEL_EN
    k = int'(ptr_m);
`else
    k = int'(s_i);
`endif
    #1;
    exp_ready = !rst_i && (exp_q[k].size() == 0 || r_i[k]);
    check("in_ready", int'(in_ready), int'(exp_ready));
    if (rst_i) begin
      for (int c = 0; c < 4; c++) begin
        exp_q[c].delete();
        cnt_m[c] = '0;
      end
      ptr_m   = 2'd0;
      started = 1'b1;
    end else if (valid_i && exp_ready) begin
      exp_q[k].push_back(d_i);
      cnt_m[k] = cnt_m[k] + 1'b1;
      ptr_m    = ptr_m + 2'd1;
    end
  endtask

  task automatic check_cleared();
    @(negedge clk);
    #1;
    for (int c = 0; c < 4; c++) begin
      check($sformatf("rst_f%0d", c), int'(f_of(c)), 0);
      check($sformatf("rst_cnt%0d", c), int'(cnt_of(c)), 0);
    end
  endtask

  // Monitor: just before each edge, every channel that will drain must hold the oldest expected word.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (!rst) begin
        for (int c = 0; c < 4; c++) begin
          if (v_of(c) && r_of(c)) begin
            if (exp_q[c].size() == 0) begin
              checks++;
              errors++;
              $display("FAIL drain_ch%0d actual=%0h expected=none at %0t", c, f_of(c), $time);
            end else begin
              check($sformatf("data_ch%0d", c), int'(f_of(c)), int'(exp_q[c].pop_front()));
            end
          end
        end
      end
    end
  end

  initial begin
    // Reset with a live offer, then confirm everything is cleared.
    cycle(1'b1, 2'd0, 4'hF, 1'b1, 4'hF);
    cycle(1'b1, 2'd0, 4'hF, 1'b1, 4'hF);
    check_cleared();
    cycle(1'b0, 2'd0, 4'h0, 1'b0, 4'hF);

    // Basic route to ch2, then stall on it.
    cycle(1'b0, 2'd2, 4'hA, 1'b1, 4'h0);
    cycle(1'b0, 2'd2, 4'h5, 1'b1, 4'h0);
    cycle(1'b0, 2'd2, 4'h0, 1'b0, 4'h4);

    // Backpressure on ch1 holding 3, then release and reload with 7.
    cycle(1'b0, 2'd1, 4'h3, 1'b1, 4'h0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 2'd1, 4'h7, 1'b1, 4'h0);
    cycle(1'b0, 2'd1, 4'h7, 1'b1, 4'h2);
    cycle(1'b0, 2'd1, 4'h0, 1'b0, 4'h2);

    // Stream into ch0 while a preloaded ch3 drains.
    cycle(1'b0, 2'd3, 4'h9, 1'b1, 4'h0);
    for (int i = 1; i <= 4; i++) cycle(1'b0, 2'd0, 4'(i), 1'b1, 4'h9);
    cycle(1'b0, 2'd0, 4'h0, 1'b0, 4'hF);

    // Counter wrap on ch2 from a fresh reset.
    cycle(1'b1, 2'd0, 4'h0, 1'b0, 4'h0);
    for (int i = 0; i < 256; i++) cycle(1'b0, 2'd2, 4'($urandom_range(0, 15)), 1'b1, 4'hF);
    cycle(1'b0, 2'd0, 4'h0, 1'b0, 4'hF);
`ifndef DEMUX_AUTO_SEL_EN
    check("cnt2_wrap", int'(cnt2), 0);
`endif

    // Mid-operation reset with a full ch1 and an offered accept.
    cycle(1'b0, 2'd1, 4'hC, 1'b1, 4'h0);
    cycle(1'b1, 2'd1, 4'h5, 1'b1, 4'h0);
    check_cleared();

    // Round-robin style sequence (also a plain ch0 stream without the feature).
    for (int i = 1; i <= 5; i++) cycle(1'b0, 2'd0, 4'(i), 1'b1, 4'hF);
    cycle(1'b0, 2'd0, 4'h0, 1'b0, 4'h0);
    cycle(1'b0, 2'd0, 4'h6, 1'b1, 4'h0);
    cycle(1'b0, 2'd0, 4'h6, 1'b1, 4'h0);
    cycle(1'b0, 2'd0, 4'h6, 1'b1, 4'h0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(1'b0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 9) < 7), 4'($urandom_range(0, 15)));
    end

    // Drain everything and confirm nothing is left behind.
    for (int i = 0; i < 4; i++) cycle(1'b0, 2'd0, 4'h0, 1'b0, 4'hF);
    for (int c = 0; c < 4; c++) check($sformatf("leftover_ch%0d", c), exp_q[c].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
